// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the system bus arbiter.
// Round-robin selection is enabled by defining BUS_ARB_ROUND_ROBIN_EN.
package bus_arb_pkg;

  localparam int NUM_REQ_DEF = 8;
  localparam int IDX_W_DEF   = 3;
  localparam int MAX_REQ     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  function automatic logic [MAX_REQ-1:0] idx2oh(
    input logic [3:0] idx
  );
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_sel.sv
// Rotating lowest-set-bit picker: rotate by start pointer,
// encode the lowest set bit, then undo the rotation.
module arb_prio_sel #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_cand,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  logic [NUM_REQ-1:0] w_rot;
  logic [IDX_W-1:0]   w_off;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_cand[IDX_W'((i + int'(i_ptr)) % NUM_REQ)];
    end
    w_off   = '0;
    o_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off   = IDX_W'(i);
      end
    end
    o_idx = IDX_W'((int'(w_off) + int'(i_ptr)) % NUM_REQ);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-bus arbiter with registered one-hot grant and turnaround.
// Define BUS_ARB_ROUND_ROBIN_EN for rotating priority.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               bus_busy,
  output logic               preempt
);

  localparam int CNT_W =
    (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM =
    (MAX_HOLD == 0) ? '1 : CNT_W'(MAX_HOLD);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_mask;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic               r_busy;
  logic               r_pre;

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_oh;
  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_win;
  logic               w_found;
  logic               w_enter;

  assign w_cand  = req & ~r_mask;
  assign w_oh    = NUM_REQ'(idx2oh(4'(w_win)));
  assign w_enter = w_found &&
                   (r_state == IDLE || r_state == TURN);

  arb_prio_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .i_cand  (w_cand),
    .i_ptr   (w_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr;

  assign w_ptr = r_rr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_enter) begin
      r_rr <= IDX_W'((int'(w_win) + 1) % NUM_REQ);
    end
  end
`else
  assign w_ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_mask  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_pre   <= 1'b0;
    end else begin
      r_pre <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWNED;
            r_gnt   <= w_oh;
            r_idx   <= w_win;
            r_cnt   <= CNT_W'(1);
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        OWNED: begin
          if (!req[r_idx]) begin
            r_state <= TURN;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end else if (MAX_HOLD != 0 && r_cnt == CNT_LIM) begin
            // forced release masks the old owner for one pick
            r_state <= TURN;
            r_mask  <= r_gnt;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_pre   <= 1'b1;
          end else if (r_cnt != CNT_LIM) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TURN: begin
          r_mask <= '0;
          if (w_found) begin
            r_state <= OWNED;
            r_gnt   <= w_oh;
            r_idx   <= w_win;
            r_cnt   <= CNT_W'(1);
            r_valid <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_idx   = r_idx;
  assign bus_busy  = r_busy;
  assign preempt   = r_pre;

endmodule
